// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 256 x 64-bit data memory between the CPU core
// and the ring NIC, with a bounded NIC lock mode and registered per-port read data.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic        nic_req,
    input  logic        nic_wr,
    input  logic [7:0]  nic_addr,
    input  logic [63:0] nic_wdata,
    input  logic        nic_lock,
    output logic        cpu_gnt,
    output logic        nic_gnt,
    output logic [63:0] cpu_rdata,
    output logic [63:0] nic_rdata,
    output logic        cpu_rvalid,
    output logic        nic_rvalid,
    output logic        mem_en,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    logic       last_owner_r;
    logic [3:0] burst_cnt_r;
    logic       lock_active_r;
    logic       cpu_win_s;
    logic       nic_win_s;
    logic       lock_next_s;
    logic [3:0] burst_next_s;

    // Winner selection; reset low suppresses every grant so no write slips through.
    always_comb begin
        cpu_win_s = 1'b0;
        nic_win_s = 1'b0;
        if (!reset) begin
            cpu_win_s = 1'b0;
            nic_win_s = 1'b0;
        end else if (cpu_req && nic_req) begin
            if (lock_active_r && (burst_cnt_r < MAX_BURST_C)) begin
                nic_win_s = 1'b1;
            end else if (last_owner_r) begin
                cpu_win_s = 1'b1;
            end else begin
                nic_win_s = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_win_s = 1'b1;
        end else if (nic_req) begin
            nic_win_s = 1'b1;
        end else begin
            cpu_win_s = 1'b0;
            nic_win_s = 1'b0;
        end
    end

    // Memory-side mux follows the winner and idles at zero.
    always_comb begin
        cpu_gnt   = cpu_win_s;
        nic_gnt   = nic_win_s;
        mem_en    = cpu_win_s | nic_win_s;
        mem_wr_en = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 64'h0;
        case ({cpu_win_s, nic_win_s})
            2'b10: begin
                mem_wr_en = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            2'b01: begin
                mem_wr_en = nic_wr;
                mem_addr  = nic_addr;
                mem_wdata = nic_wdata;
            end
            default: begin
                mem_wr_en = 1'b0;
                mem_addr  = 8'h00;
                mem_wdata = 64'h0;
            end
        endcase
    end

    // Lock/burst next state: the count only advances while the CPU is actually held off.
    always_comb begin
        lock_next_s  = lock_active_r;
        burst_next_s = burst_cnt_r;
        if (cpu_win_s || !nic_req) begin
            lock_next_s  = 1'b0;
            burst_next_s = 4'd0;
        end else if (nic_win_s) begin
            if (!nic_lock) begin
                lock_next_s  = 1'b0;
                burst_next_s = 4'd0;
            end else begin
                lock_next_s = 1'b1;
                if (lock_active_r && cpu_req && (burst_cnt_r < MAX_BURST_C)) begin
                    burst_next_s = burst_cnt_r + 4'd1;
                end else begin
                    burst_next_s = burst_cnt_r;
                end
            end
        end else begin
            lock_next_s  = lock_active_r;
            burst_next_s = burst_cnt_r;
        end
    end

    // Arbitration state; last_owner resets to NIC so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_owner_r  <= 1'b1;
            burst_cnt_r   <= 4'd0;
            lock_active_r <= 1'b0;
        end else begin
            if (cpu_win_s) begin
                last_owner_r <= 1'b0;
            end else if (nic_win_s) begin
                last_owner_r <= 1'b1;
            end
            burst_cnt_r   <= burst_next_s;
            lock_active_r <= lock_next_s;
        end
    end

    // Read return path: capture at the granting edge, rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_rdata  <= 64'h0;
            nic_rdata  <= 64'h0;
            cpu_rvalid <= 1'b0;
            nic_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_win_s & ~cpu_wr;
            nic_rvalid <= nic_win_s & ~nic_wr;
            if (cpu_win_s && !cpu_wr) begin
                cpu_rdata <= mem_rdata;
            end
            if (nic_win_s && !nic_wr) begin
                nic_rdata <= mem_rdata;
            end
        end
    end

endmodule
